// File: rtl/mbox_req_seq_pkg.sv
// Shared EBOX/MBOX definitions: word and VMA widths, sequencer
// states and the reference-op encoding.
package mbox_req_seq_pkg;

    localparam int VMA_W  = 23;
    localparam int WORD_W = 36;

    typedef logic [13:13+VMA_W-1] vma_t;
    typedef logic [0:WORD_W-1]    word_t;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RD    = 2'd1;
    localparam logic [1:0] ST_WR    = 2'd2;
    localparam logic [1:0] ST_PAUSE = 2'd3;

    localparam logic [1:0] OP_NONE = 2'd0;
    localparam logic [1:0] OP_RD   = 2'd1;
    localparam logic [1:0] OP_RPW  = 2'd2;
    localparam logic [1:0] OP_WR   = 2'd3;

    // PSE only qualifies a read; a write with PSE is a plain write.
    function automatic logic [1:0] op_decode(input logic rd,
                                             input logic wr,
                                             input logic pse);
        logic [1:0] op;
        op = OP_NONE;
        if (rd && !wr) op = pse ? OP_RPW : OP_RD;
        if (wr && !rd) op = OP_WR;
        return op;
    endfunction

endpackage

// File: rtl/mbox_req_seq.sv
// EBOX-side request sequencer: issues one MBOX reference at a time,
// times the read latency and returns data with a done pulse.
module mbox_req_seq
    import mbox_req_seq_pkg::*;
#(
    parameter int RD_LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        eboxReq,
    input  logic        eboxRead,
    input  logic        eboxWrite,
    input  logic        eboxPSE,
    input  logic        eboxAbort,
    input  logic [13:35] eboxVMA,
    input  logic        eboxVMAACRef,
    input  logic [0:35] eboxWriteData,
    output logic        eboxBusy,
    output logic        eboxDone,
    output logic [0:35] eboxMB,
    output logic        eboxProtoErr,
    output logic        mboxReq,
    output logic        mboxRead,
    output logic        mboxWrite,
    output logic        mboxPSE,
    output logic [13:35] mboxVMA,
    output logic        mboxVMAACRef,
    output logic [0:35] mboxWriteData,
    input  logic [0:35] mboxData
);

    logic [1:0] state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       rpw_q, rpw_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       perr_q, perr_d;
    word_t      mb_q, mb_d;
    logic       mreq_q, mreq_d;
    logic       mrd_q, mrd_d;
    logic       mwr_q, mwr_d;
    logic       mpse_q, mpse_d;
    vma_t       mvma_q, mvma_d;
    logic       mac_q, mac_d;
    word_t      mwd_q, mwd_d;
    logic [1:0] op;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rpw_d   = rpw_q;
        done_d  = 1'b0;
        perr_d  = perr_q;
        mb_d    = mb_q;
        mreq_d  = 1'b0;
        mrd_d   = 1'b0;
        mwr_d   = 1'b0;
        mpse_d  = 1'b0;
        mvma_d  = mvma_q;
        mac_d   = mac_q;
        mwd_d   = mwd_q;
        op      = op_decode(eboxRead, eboxWrite, eboxPSE);

        case (state_q)
            ST_IDLE: begin
                if (eboxReq && op == OP_NONE) begin
                    perr_d = 1'b1;
                end else if (eboxReq) begin
                    mvma_d = eboxVMA;
                    mac_d  = eboxVMAACRef;
                    mwd_d  = eboxWriteData;
                    mreq_d = 1'b1;
                    if (op == OP_WR) begin
                        mwr_d   = 1'b1;
                        rpw_d   = 1'b0;
                        state_d = ST_WR;
                    end else begin
                        mrd_d   = 1'b1;
                        mpse_d  = (op == OP_RPW);
                        rpw_d   = (op == OP_RPW);
                        cnt_d   = 4'(RD_LATENCY);
                        state_d = ST_RD;
                    end
                end
            end
            ST_RD: begin
                if (eboxAbort) begin
                    cnt_d   = 4'd0;
                    state_d = ST_IDLE;
                end else begin
                    if (eboxReq) perr_d = 1'b1;
                    if (cnt_q != 4'd0) begin
                        cnt_d = cnt_q - 4'd1;
                    end else begin
                        mb_d    = mboxData;
                        done_d  = 1'b1;
                        state_d = rpw_q ? ST_PAUSE : ST_IDLE;
                    end
                end
            end
            ST_WR: begin
                if (eboxAbort) begin
                    state_d = ST_IDLE;
                end else begin
                    if (eboxReq) perr_d = 1'b1;
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_PAUSE: begin
                // VMA stays locked to the read phase; only data is new.
                if (eboxAbort) begin
                    state_d = ST_IDLE;
                end else if (eboxReq && eboxWrite && !eboxRead) begin
                    mwd_d   = eboxWriteData;
                    mreq_d  = 1'b1;
                    mwr_d   = 1'b1;
                    rpw_d   = 1'b0;
                    state_d = ST_WR;
                end else if (eboxReq) begin
                    perr_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Busy stays high through the done cycle itself.
        busy_d = (state_d != ST_IDLE) || done_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            rpw_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            perr_q  <= 1'b0;
            mb_q    <= '0;
            mreq_q  <= 1'b0;
            mrd_q   <= 1'b0;
            mwr_q   <= 1'b0;
            mpse_q  <= 1'b0;
            mvma_q  <= '0;
            mac_q   <= 1'b0;
            mwd_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rpw_q   <= rpw_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            perr_q  <= perr_d;
            mb_q    <= mb_d;
            mreq_q  <= mreq_d;
            mrd_q   <= mrd_d;
            mwr_q   <= mwr_d;
            mpse_q  <= mpse_d;
            mvma_q  <= mvma_d;
            mac_q   <= mac_d;
            mwd_q   <= mwd_d;
        end
    end

    assign eboxBusy      = busy_q;
    assign eboxDone      = done_q;
    assign eboxMB        = mb_q;
    assign eboxProtoErr  = perr_q;
    assign mboxReq       = mreq_q;
    assign mboxRead      = mrd_q;
    assign mboxWrite     = mwr_q;
    assign mboxPSE       = mpse_q;
    assign mboxVMA       = mvma_q;
    assign mboxVMAACRef  = mac_q;
    assign mboxWriteData = mwd_q;

endmodule
